// File: rtl/spi_color_loader.sv
// spi_color_loader
//   Receives per-LED colour bytes from an MCU over mode-0 SPI (MCU is master)
//   and assembles them into a 24*NUM_LEDS-bit working buffer. The buffer is
//   copied to color_string only when a complete, well-formed frame has been
//   received, so color_string never shows a partially written frame.
//
//   Optional feature: define SPI_COLOR_LOADER_CHECKSUM_EN to expect one extra
//   trailing byte per frame holding the XOR of all colour bytes.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   sck          in   SPI clock (asynchronous to clk)
//   sdi          in   SPI data, MSB first, sampled on sck rise
//   cs_n         in   SPI chip select, active low, one frame per assertion
//   color_string out  committed frame, LED 0 in the MSBs, each LED {G,R,B}
//   frame_valid  out  one-cycle pulse when a frame is committed
//   frame_err    out  one-cycle pulse when a frame is discarded
module spi_color_loader #(
    parameter int unsigned NUM_LEDS = 144
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sck,
    input  logic                    sdi,
    input  logic                    cs_n,
    output logic [24*NUM_LEDS-1:0]  color_string,
    output logic                    frame_valid,
    output logic                    frame_err
);

    localparam int unsigned W  = 24 * NUM_LEDS;
    localparam int unsigned FB = 3 * NUM_LEDS;
`ifdef SPI_COLOR_LOADER_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = FB + 1;
`else
    localparam int unsigned FRAME_LEN = FB;
`endif
    localparam int unsigned CW = $clog2(FB + 2);
    localparam logic [CW-1:0] FB_C  = CW'(FB);
    localparam logic [CW-1:0] LEN_C = CW'(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHECK
    } state_t;

    logic [2:0]    sck_sync_q;
    logic [1:0]    sdi_sync_q;
    logic [2:0]    cs_sync_q;

    state_t        state_q,    state_d;
    logic [2:0]    bit_cnt_q,  bit_cnt_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic          ovf_q,      ovf_d;
    logic [7:0]    xor_q,      xor_d;
    logic          csum_bad_q, csum_bad_d;
    logic [6:0]    shreg_q,    shreg_d;
    logic [W-1:0]  work_q,     work_d;
    logic [W-1:0]  color_q,    color_d;
    logic          valid_q,    valid_d;
    logic          err_q,      err_d;
    logic [1:0]    settle_q,   settle_d;
    logic          armed_q,    armed_d;

    logic          sck_rise, cs_fall, cs_rise, sdi_s;
    logic [7:0]    new_byte;
    logic          frame_ok;

    assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    assign cs_fall  = ~cs_sync_q[1] & cs_sync_q[2];
    assign cs_rise  = cs_sync_q[1] & ~cs_sync_q[2];
    assign sdi_s    = sdi_sync_q[1];
    // The eighth bit of each byte is the live synchronised sdi sample.
    assign new_byte = {shreg_q, sdi_s};

    // The synchronisers reset to idle levels, so a cs_n pin that is already
    // low when reset releases looks like a falling edge. A fall is accepted
    // only once the pipeline has flushed and cs_n has been seen high, which
    // discards the tail of a frame interrupted by reset.
    assign frame_ok = (bit_cnt_q == 3'd0) && (byte_cnt_q == LEN_C) && !ovf_q
                      && !csum_bad_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '1;
        end else begin
            sck_sync_q <= {sck_sync_q[1:0], sck};
            sdi_sync_q <= {sdi_sync_q[0], sdi};
            cs_sync_q  <= {cs_sync_q[1:0], cs_n};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            ovf_q      <= 1'b0;
            xor_q      <= '0;
            csum_bad_q <= 1'b0;
            shreg_q    <= '0;
            work_q     <= '0;
            color_q    <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            settle_q   <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            ovf_q      <= ovf_d;
            xor_q      <= xor_d;
            csum_bad_q <= csum_bad_d;
            shreg_q    <= shreg_d;
            work_q     <= work_d;
            color_q    <= color_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            settle_q   <= settle_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = ovf_q;
        xor_d      = xor_q;
        csum_bad_d = csum_bad_q;
        shreg_d    = shreg_q;
        work_d     = work_q;
        color_d    = color_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        settle_d   = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        armed_d    = armed_q | ((settle_q == 2'd3) && cs_sync_q[2]);

        case (state_q)
            S_IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d    = S_RECV;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    ovf_d      = 1'b0;
                    xor_d      = '0;
                    csum_bad_d = 1'b0;
                end
            end
            S_RECV: begin
                // An sck rise coinciding with a cs rise is still captured.
                if (sck_rise) begin
                    shreg_d   = new_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (byte_cnt_q < FB_C) begin
                            work_d     = {work_q[W-9:0], new_byte};
                            xor_d      = xor_q ^ new_byte;
                            byte_cnt_d = byte_cnt_q + CW'(1);
                        end
`ifdef SPI_COLOR_LOADER_CHECKSUM_EN
                        else if (byte_cnt_q == FB_C) begin
                            csum_bad_d = (new_byte != xor_q);
                            byte_cnt_d = byte_cnt_q + CW'(1);
                        end
`endif
                        else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                if (cs_rise) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (frame_ok) begin
                    color_d = work_q;
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign color_string = color_q;
    assign frame_valid  = valid_q;
    assign frame_err    = err_q;

endmodule

// File: tb/tb_spi_color_loader.sv
// Testbench for spi_color_loader: drives SPI frames at f_sck = f_clk/6 and
// checks commit/discard pulses, their latency and the committed buffer.
`timescale 1ns/1ps
module tb_spi_color_loader;

    localparam int unsigned N  = 12;
    localparam int unsigned W  = 24 * N;
    localparam int unsigned FB = 3 * N;
    localparam int unsigned H  = 3;
`ifdef SPI_COLOR_LOADER_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif
    localparam int TAIL_OK = CSUM;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         sck  = 1'b0;
    logic         sdi  = 1'b0;
    logic         cs_n = 1'b1;
    logic [W-1:0] color_string;
    logic         frame_valid;
    logic         frame_err;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_cs;

    always #5 clk = ~clk;

    spi_color_loader #(.NUM_LEDS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .sck          (sck),
        .sdi          (sdi),
        .cs_n         (cs_n),
        .color_string (color_string),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err)
    );

    typedef struct {
        int pid;
        int nbytes;
        int xbits;
        int tail;     // 0 none, 1 XOR of colour bytes, 2 that XOR ^ 8'h01
        bit exp_ok;
    } vec_t;

    vec_t vecs[6];

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int pid, input int k);
        int r;
        case (pid)
            0: begin
                r = k % 18;
                if (r >= 9)          return 8'h00;
                else if (r % 3 == 0) return 8'h00;
                else if (r % 3 == 1) return 8'hCE;
                else                 return 8'hFF;
            end
            1:       return 8'(k * 7 + 3);
            2:       return 8'(8'hA5 ^ 8'(k * 13));
            default: return 8'(255 - k * 5);
        endcase
    endfunction

    function automatic logic [W-1:0] build_buf(input int pid);
        logic [W-1:0] b;
        b = '0;
        for (int k = 0; k < int'(FB); k++) begin
            b[W-1-8*k -: 8] = pat_byte(pid, k);
        end
        return b;
    endfunction

    // Sends nb bits MSB first; with fast_end the final sck rise and the cs_n
    // rise are driven together and sck is left high.
    task automatic send_bits(input logic [7:0] b, input int nb, input bit fast_end);
        for (int i = 0; i < nb; i++) begin
            sdi = b[7-i];
            nclk(H);
            sck = 1'b1;
            if (fast_end && i == nb - 1) begin
                cs_n = 1'b1;
                return;
            end
            nclk(H);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int pid, input int nbytes, input int xbits,
                             input int tail, input bit fast,
                             output logic [9:0] vh, output logic [9:0] eh);
        logic [7:0] x;
        logic [7:0] b;
        x = '0;
        cs_n = 1'b0;
        nclk(2 * H);
        for (int k = 0; k < nbytes; k++) begin
            b = pat_byte(pid, k);
            x = x ^ b;
            send_bits(b, 8, fast && k == nbytes - 1 && tail == 0 && xbits == 0);
        end
        if (tail != 0) send_bits((tail == 1) ? x : (x ^ 8'h01), 8, fast && xbits == 0);
        if (xbits != 0) send_bits(8'hB6, xbits, 1'b0);
        if (!fast) begin
            nclk(H);
            cs_n = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vh[i] = frame_valid;
            eh[i] = frame_err;
            if (fast && i == 2) sck = 1'b0;
        end
    endtask

    initial begin
        logic [9:0] vh, eh, ev_ok, ev_none;
        logic [143:0] pat144;
        logic [7:0] x;
        logic [7:0] b;

        ev_ok   = 10'b00_0000_1000;   // pulse on the 4th falling edge after cs_n rises
        ev_none = '0;
        pat144  = 144'h00CEFF_00CEFF_00CEFF_000000_000000_000000;
        exp_cs  = '0;

        vecs[0] = '{pid: 0, nbytes: FB,     xbits: 0, tail: TAIL_OK, exp_ok: 1'b1};
        vecs[1] = '{pid: 1, nbytes: FB,     xbits: 0, tail: TAIL_OK, exp_ok: 1'b1};
        vecs[2] = '{pid: 2, nbytes: FB - 1, xbits: 0, tail: TAIL_OK, exp_ok: 1'b0};
        vecs[3] = '{pid: 2, nbytes: FB,     xbits: 3, tail: TAIL_OK, exp_ok: 1'b0};
        vecs[4] = '{pid: 2, nbytes: FB,     xbits: 0, tail: 2,       exp_ok: 1'b0};
        vecs[5] = '{pid: 2, nbytes: FB,     xbits: 0, tail: 1,       exp_ok: bit'(CSUM)};

        nclk(3);
        chk("reset_color", color_string, '0);
        chk("reset_valid", W'(frame_valid), '0);
        chk("reset_err",   W'(frame_err), '0);
        rst = 1'b0;
        nclk(8);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].pid, vecs[i].nbytes, vecs[i].xbits, vecs[i].tail, 1'b0, vh, eh);
            chk($sformatf("vec%0d_valid", i), W'(vh), W'(vecs[i].exp_ok ? ev_ok : ev_none));
            chk($sformatf("vec%0d_err", i),   W'(eh), W'(vecs[i].exp_ok ? ev_none : ev_ok));
            if (vecs[i].exp_ok) exp_cs = build_buf(vecs[i].pid);
            chk($sformatf("vec%0d_color", i), color_string, exp_cs);
            if (i == 0) chk("vec0_pattern", color_string, {2{pat144}});
            nclk(4);
        end

        // Reset in the middle of a frame; its remainder must be ignored.
        cs_n = 1'b0;
        nclk(2 * H);
        x = '0;
        for (int k = 0; k < 20; k++) begin
            b = pat_byte(1, k);
            x = x ^ b;
            send_bits(b, 8, 1'b0);
        end
        rst = 1'b1;
        nclk(1);
        rst = 1'b0;
        exp_cs = '0;
        chk("midrst_color", color_string, exp_cs);
        chk("midrst_valid", W'(frame_valid), '0);
        chk("midrst_err",   W'(frame_err), '0);
        for (int k = 20; k < int'(FB); k++) begin
            b = pat_byte(1, k);
            x = x ^ b;
            send_bits(b, 8, 1'b0);
        end
        if (CSUM != 0) send_bits(x, 8, 1'b0);
        nclk(H);
        cs_n = 1'b1;
        vh = '0;
        eh = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vh[i] = frame_valid;
            eh[i] = frame_err;
        end
        chk("midrst_tail_valid", W'(vh), '0);
        chk("midrst_tail_err",   W'(eh), '0);
        chk("midrst_tail_color", color_string, exp_cs);
        nclk(4);

        run_frame(3, FB, 0, TAIL_OK, 1'b0, vh, eh);
        exp_cs = build_buf(3);
        chk("after_rst_valid", W'(vh), W'(ev_ok));
        chk("after_rst_err",   W'(eh), '0);
        chk("after_rst_color", color_string, exp_cs);
        nclk(4);

        // cs_n rises in the same cycle as the final sck rise.
        run_frame(2, FB, 0, TAIL_OK, 1'b1, vh, eh);
        exp_cs = build_buf(2);
        chk("fast_end_valid", W'(vh), W'(ev_ok));
        chk("fast_end_err",   W'(eh), '0);
        chk("fast_end_color", color_string, exp_cs);
        nclk(10);
        chk("stable_color", color_string, exp_cs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
